rr_priority_encoder_32to5: RTL and testbench
============================================

Name: rr_priority_encoder_32to5

Overview:
- Inverse of the register-select decoder: collects up to 32 one-hot or multi-hot request lines into a sticky pending set.
- Emits one 5-bit index at a time over a valid/ready handshake, selected by round-robin (or fixed) priority.
- Used to serialise multi-source events (pending register writebacks, interrupt/exception sources) into a single indexed stream for the control path.

Parameters:
N_REQ, 32, number of request lines (fixed at 32 for this block)
IDX_W, 5, index width, log2(N_REQ)
ROUND_ROBIN, 1, 1 = rotating priority starting after last grant; 0 = fixed priority, lowest index wins

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_in  input  32  request pulses; bit i set for one or more cycles marks source i pending
clear_all  input  1  synchronous flush of pending set and output stage
out_idx  output  5  selected source index
out_valid  output  1  out_idx holds a valid selection
out_ready  input  1  consumer accepts out_idx when out_valid & out_ready
pending  output  32  current sticky pending set (registered)
overflow  output  1  one-cycle pulse: a request arrived for a bit already pending

Behaviour:
- Reset (async, active-high): pending=0, out_valid=0, out_idx=0, overflow=0, rotate pointer ptr=0. Reset mid-transfer discards any held selection and all pending bits.
- Output stage load condition: load = (!out_valid | out_ready) & (|pending) & !clear_all.
- Selection: search pending from bit ptr upward, wrapping 31->0; the first set bit is k. With ROUND_ROBIN=0 the search always starts at bit 0.
- On load:
  - out_idx<=k, out_valid<=1, pending[k] cleared.
  - ptr<=(k+1) mod 32 (5-bit wrap).
- Out_valid clears: if out_valid & out_ready & !load, out_valid<=0 and out_idx holds its last value.
- Output stability: while out_valid & !out_ready, out_idx and out_valid hold stable (no re-selection, ptr unchanged).
- Pending update, priority order:
  - clear_all: pending<=0, out_valid<=0, same-cycle req_in dropped, ptr retained.
  - Otherwise pending <= (pending & ~load_mask) | req_in. A req_in bit equal to the bit loaded this cycle re-sets it (the new request is retained).
- Selection uses registered pending only; req_in does not bypass.
- Latency: req_in at cycle t → pending at t+1 → out_valid at t+2 (if the stage is free).
- Throughput: one index per cycle with out_ready held high.
- overflow: registered pulse at t+1 when req_in[i] & pending[i] & !(load & k==i) at t, for any i. The requests merge; only one grant is issued. overflow=0 on cycles with clear_all.
- Empty: pending=0 with stage free → out_valid falls after last accept; no spurious index.
- Full: all 32 pending → 32 consecutive grants in rotating order, no loss.

Test Plan:
1. Assert reset during out_valid=1 with pending=0xFFFF_FFFF → all outputs 0 immediately (async); after release, no out_valid until new req_in.
2. req_in=0x0000_0080 for 1 cycle at t, out_ready=1 → pending=0x80 at t+1; out_valid=1, out_idx=7 at t+2; out_valid=0 at t+3.
3. ptr=0, req_in=0x8000_0011 one cycle, out_ready=1 → out_idx 0, 4, 31 on three consecutive cycles; ptr ends 0; a second burst with bits 2 and 30 yields 2, 30. With ROUND_ROBIN=0 and ptr irrelevant, the same burst yields 0, 4, 31.
4. Grant idx 4 (ptr=5), then req_in bits 2 and 6 → order 6 then 2 (wrap-around).
5. Backpressure: out_idx=9 valid, out_ready=0 for 5 cycles while bits 1 and 20 arrive → out_idx stays 9; pending=0x0010_0002 retained; on ready → 20 then 1 (ptr=10).
6. req_in bit 3 at t, again at t+1 with out_ready=0 and stage holding another index → overflow pulses at t+2 only, single grant of 3. Separately, clear_all with out_valid=1 → next cycle out_valid=0, pending=0, overflow=0.

Source files
------------

// File: rtl/rr_priority_encoder_32to5.sv
// Sticky 32-source request collector that serialises pending sources into a
// stream of 5-bit indices, using round-robin or fixed lowest-index priority.
module rr_priority_encoder_32to5 #(
  parameter int N_REQ       = 32,
  parameter int IDX_W       = 5,
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_in,
  input  logic             clear_all,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  // Handshake: out_idx transfers on a rising edge where out_valid & out_ready.
  // Once out_valid is high, out_idx and out_valid hold until that transfer
  // (or a clear_all/reset flush); out_ready may change freely.

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   off;
  logic [IDX_W-1:0]   k;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   load_mask;
  logic               load;
  logic               overflow_nxt;

  assign start = (ROUND_ROBIN != 0) ? ptr : '0;

  // Rotate pending so bit 'start' lands at position 0, then pick the lowest
  // set bit; adding start back (mod 32) gives the wrapped source index.
  assign dbl = {pending, pending} >> start;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign k    = start + off;
  assign load = (!out_valid || out_ready) && (|pending) && !clear_all;

  assign load_mask    = load ? (N_REQ'(1) << k) : '0;
  assign overflow_nxt = !clear_all && (|(req_in & pending & ~load_mask));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      overflow  <= 1'b0;
      ptr       <= '0;
    end else begin
      overflow <= overflow_nxt;
      if (clear_all) begin
        pending   <= '0;
        out_valid <= 1'b0;
      end else begin
        pending <= (pending & ~load_mask) | req_in;
        if (load) begin
          out_idx   <= k;
          out_valid <= 1'b1;
          ptr       <= k + IDX_W'(1);
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder_32to5.sv
// Directed bench for rr_priority_encoder_32to5: a round-robin and a fixed
// priority instance, each with an expected-index queue drained by a monitor.
module tb_rr_priority_encoder_32to5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] req_in = '0;
  logic        clear_all = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic [31:0] pending;
  logic        overflow;

  logic [31:0] req_fx = '0;
  logic [4:0]  idx_fx;
  logic        valid_fx;
  logic [31:0] pend_fx;
  logic        ovf_fx;

  logic [4:0] exp_q[$];
  logic [4:0] exp_fx_q[$];
  int n_cmp = 0;
  int n_err = 0;

  rr_priority_encoder_32to5 #(.ROUND_ROBIN(1)) dut (
    .clock(clock), .reset(reset), .req_in(req_in), .clear_all(clear_all),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .overflow(overflow)
  );

  rr_priority_encoder_32to5 #(.ROUND_ROBIN(0)) dut_fx (
    .clock(clock), .reset(reset), .req_in(req_fx), .clear_all(clear_all),
    .out_idx(idx_fx), .out_valid(valid_fx), .out_ready(1'b1),
    .pending(pend_fx), .overflow(ovf_fx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: inputs change just after posedge, so at negedge a visible
  // valid & ready is the transfer that the next posedge completes.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("rr_unexpected_grant", {27'd0, out_idx}, 32'hFFFF_FFFF);
      else check("rr_grant", {27'd0, out_idx}, {27'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clock) begin
    if (!reset && valid_fx) begin
      if (exp_fx_q.size() == 0) check("fx_unexpected_grant", {27'd0, idx_fx}, 32'hFFFF_FFFF);
      else check("fx_grant", {27'd0, idx_fx}, {27'd0, exp_fx_q.pop_front()});
    end
  end

  initial begin
    // Reset state
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_idx", {27'd0, out_idx}, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Async reset while a selection is held and every bit is pending
    out_ready = 1'b0;
    req_in = 32'hFFFF_FFFF;
    tick();
    tick();
    req_in = '0;
    check("t1_valid_before", {31'd0, out_valid}, 32'd1);
    check("t1_pending_before", pending, 32'hFFFF_FFFF);
    #2 reset = 1'b1;
    #1;
    check("t1_async_valid", {31'd0, out_valid}, 32'd0);
    check("t1_async_pending", pending, 32'd0);
    check("t1_async_idx", {27'd0, out_idx}, 32'd0);
    check("t1_async_ovf", {31'd0, overflow}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t1_no_valid_after", {31'd0, out_valid}, 32'd0);

    // Single request latency
    out_ready = 1'b1;
    req_in = 32'h0000_0080;
    exp_q.push_back(5'd7);
    tick();
    req_in = '0;
    check("t2_pending", pending, 32'h80);
    check("t2_valid_t1", {31'd0, out_valid}, 32'd0);
    tick();
    check("t2_valid_t2", {31'd0, out_valid}, 32'd1);
    check("t2_idx", {27'd0, out_idx}, 32'd7);
    tick();
    check("t2_valid_t3", {31'd0, out_valid}, 32'd0);

    // Round-robin burst from ptr=0; fixed instance first advances its ptr
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_fx = 32'h0000_0400;
    exp_fx_q.push_back(5'd10);
    tick();
    req_fx = '0;
    repeat (3) tick();
    req_in = 32'h8000_0011;
    req_fx = 32'h8000_0011;
    exp_q.push_back(5'd0);  exp_q.push_back(5'd4);  exp_q.push_back(5'd31);
    exp_fx_q.push_back(5'd0); exp_fx_q.push_back(5'd4); exp_fx_q.push_back(5'd31);
    tick();
    req_in = '0;
    req_fx = '0;
    tick();
    check("t3_idx_a", {27'd0, out_idx}, 32'd0);
    tick();
    check("t3_idx_b", {27'd0, out_idx}, 32'd4);
    tick();
    check("t3_idx_c", {27'd0, out_idx}, 32'd31);
    tick();
    check("t3_drained", {31'd0, out_valid}, 32'd0);
    req_in = 32'h4000_0004;
    exp_q.push_back(5'd2); exp_q.push_back(5'd30);
    tick();
    req_in = '0;
    repeat (3) tick();

    // Wrap-around: grant 4 then bits 2 and 6
    req_in = 32'h0000_0010;
    exp_q.push_back(5'd4);
    tick();
    req_in = '0;
    repeat (2) tick();
    req_in = 32'h0000_0044;
    exp_q.push_back(5'd6); exp_q.push_back(5'd2);
    tick();
    req_in = '0;
    tick();
    check("t4_idx_a", {27'd0, out_idx}, 32'd6);
    tick();
    check("t4_idx_b", {27'd0, out_idx}, 32'd2);
    tick();

    // Backpressure holds idx 9 while new requests collect
    out_ready = 1'b0;
    req_in = 32'h0000_0200;
    exp_q.push_back(5'd9);
    tick();
    req_in = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_in = (i == 0) ? 32'h0010_0002 : 32'h0;
      tick();
      check("t5_hold_idx", {27'd0, out_idx}, 32'd9);
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    req_in = '0;
    check("t5_pending", pending, 32'h0010_0002);
    exp_q.push_back(5'd20); exp_q.push_back(5'd1);
    out_ready = 1'b1;
    tick();
    check("t5_idx_a", {27'd0, out_idx}, 32'd20);
    tick();
    check("t5_idx_b", {27'd0, out_idx}, 32'd1);
    tick();

    // Overflow on a repeated request while the stage is busy
    out_ready = 1'b0;
    req_in = 32'h0000_1000;
    exp_q.push_back(5'd12);
    tick();
    req_in = '0;
    tick();
    req_in = 32'h0000_0008;
    tick();
    check("t6_ovf_first", {31'd0, overflow}, 32'd0);
    tick();
    req_in = '0;
    check("t6_ovf_pulse", {31'd0, overflow}, 32'd1);
    check("t6_pending", pending, 32'h8);
    tick();
    check("t6_ovf_end", {31'd0, overflow}, 32'd0);
    exp_q.push_back(5'd3);
    out_ready = 1'b1;
    tick();
    check("t6_idx", {27'd0, out_idx}, 32'd3);
    tick();
    check("t6_single_grant", {31'd0, out_valid}, 32'd0);
    check("t6_pending_empty", pending, 32'd0);

    // clear_all flushes the held selection and drops same-cycle requests
    out_ready = 1'b0;
    req_in = 32'h0000_0060;
    tick();
    req_in = '0;
    tick();
    check("t7_valid", {31'd0, out_valid}, 32'd1);
    check("t7_idx", {27'd0, out_idx}, 32'd5);
    clear_all = 1'b1;
    req_in = 32'h0000_0040;
    tick();
    clear_all = 1'b0;
    req_in = '0;
    check("t7_clr_valid", {31'd0, out_valid}, 32'd0);
    check("t7_clr_pending", pending, 32'd0);
    check("t7_clr_ovf", {31'd0, overflow}, 32'd0);
    tick();
    check("t7_no_spurious", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;

    begin
      int budget;
      budget = 50;
      while ((exp_q.size() != 0 || exp_fx_q.size() != 0) && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) check("drain_timeout", exp_q.size() + exp_fx_q.size(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
